// File: rtl/sram_pkg.sv
// Shared types and helpers for the SRAM ring-buffer burst scheduler.
package sram_pkg;

  typedef enum logic [2:0] {
    StIdle,
    StArb,
    StWrBusy,
    StRdBusy,
    StDrainArb
  } sched_state_e;

  localparam int unsigned DefAddrW    = 15;
  localparam int unsigned DefBurst    = 256;
  localparam int unsigned DefOutDepth = 16384;

  // Smallest of three word counts; used to size a burst.
  function automatic int unsigned min3(input int unsigned a, input int unsigned b,
                                       input int unsigned c);
    int unsigned m;
    m = (a < b) ? a : b;
    return (m < c) ? m : c;
  endfunction

endpackage

// File: rtl/sram_ring_ptr.sv
// One side of the SRAM ring: a wrapping word pointer plus its contribution to
// the shared fill count. FILL_UP selects whether advancing adds (write side)
// or removes (read side) words from the fill level passed through it.
module sram_ring_ptr #(
  parameter int unsigned ADDR_W  = 15,
  parameter bit          FILL_UP = 1'b1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              advance,
  input  logic [ADDR_W:0]   num,
  input  logic [ADDR_W:0]   fill_cur,
  output logic [ADDR_W-1:0] ptr,
  output logic [ADDR_W:0]   space_to_top,
  output logic [ADDR_W:0]   fill_next
);

  localparam logic [ADDR_W:0] Depth = {1'b1, {ADDR_W{1'b0}}};

  // Advance the pointer by the completed burst length; natural ADDR_W-bit wrap
  // gives modulo-D arithmetic (a full-depth burst leaves the pointer unchanged).
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ptr <= '0;
    end else if (advance) begin
      ptr <= ptr + num[ADDR_W-1:0];
    end
  end

  // Words left before the top of SRAM, so a burst never crosses the wrap point.
  assign space_to_top = Depth - {1'b0, ptr};

  // Fill level after this side's burst completes.
  always_comb begin
    fill_next = fill_cur;
    if (advance) begin
      if (FILL_UP) begin
        fill_next = fill_cur + num;
      end else begin
        fill_next = fill_cur - num;
      end
    end
  end

endmodule

// File: rtl/sram_ring_scheduler.sv
// Burst scheduler treating the external SRAM as a circular buffer between the
// acquisition FIFO (writes) and the USB FIFO (reads). Writes win arbitration;
// stopping a run drains residual words as partial bursts before going idle.
module sram_ring_scheduler
  import sram_pkg::*;
#(
  parameter int unsigned ADDR_W      = DefAddrW,
  parameter int unsigned BURST       = DefBurst,
  parameter int unsigned IN_UW       = 11,
  parameter int unsigned OUT_UW      = 14,
  parameter int unsigned OUT_DEPTH   = DefOutDepth,
  parameter int unsigned HALT_MARGIN = 1024
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              run_start,
  input  logic [IN_UW-1:0]  in_usedw,
  input  logic [OUT_UW-1:0] out_usedw,
  input  logic              wr_run_end,
  input  logic              rd_run_end,
  output logic              wr_start,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [ADDR_W:0]   wr_num,
  output logic              rd_start,
  output logic [ADDR_W-1:0] rd_addr,
  output logic [ADDR_W:0]   rd_num,
  output logic              data_en,
  output logic [ADDR_W:0]   fill,
  output logic              sram_full,
  output logic              sram_empty,
  output logic              busy
);

  localparam int unsigned D  = 32'd1 << ADDR_W;
  localparam int unsigned FW = ADDR_W + 1;

  sched_state_e state;
  logic         draining;

  logic [ADDR_W-1:0] wr_ptr, rd_ptr;
  logic [ADDR_W:0]   wr_top, rd_top;
  logic [ADDR_W:0]   fill_q, fill_after_wr, fill_d;
  logic              wr_adv, rd_adv;

  int unsigned fill_w, free_w, in_w, out_w, wr_top_w, rd_top_w, wr_room, wr_n, rd_n;
  logic        wr_ok_arb, wr_ok_drain, rd_ok_arb, rd_ok_drain, out_ok;

  // Completion of the burst that is actually in flight; stray end pulses drop out here.
  assign wr_adv = (state == StWrBusy) && wr_run_end;
  assign rd_adv = (state == StRdBusy) && rd_run_end;

  // Write side: owns wr_ptr, adds completed words to fill.
  sram_ring_ptr #(
    .ADDR_W (ADDR_W),
    .FILL_UP(1'b1)
  ) u_wr_ptr (
    .clk         (clk),
    .reset       (reset),
    .advance     (wr_adv),
    .num         (wr_num),
    .fill_cur    (fill_q),
    .ptr         (wr_ptr),
    .space_to_top(wr_top),
    .fill_next   (fill_after_wr)
  );

  // Read side: owns rd_ptr, removes completed words from fill.
  sram_ring_ptr #(
    .ADDR_W (ADDR_W),
    .FILL_UP(1'b0)
  ) u_rd_ptr (
    .clk         (clk),
    .reset       (reset),
    .advance     (rd_adv),
    .num         (rd_num),
    .fill_cur    (fill_after_wr),
    .ptr         (rd_ptr),
    .space_to_top(rd_top),
    .fill_next   (fill_d)
  );

  // Shared fill level register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      fill_q <= '0;
    end else begin
      fill_q <= fill_d;
    end
  end

  assign fill       = fill_q;
  assign sram_full  = (fill_w == D);
  assign sram_empty = (fill_w == 0);

  // Eligibility and burst sizing, all in zero-extended 32-bit arithmetic.
  always_comb begin
    fill_w   = 32'(fill_q);
    free_w   = D - fill_w;
    in_w     = 32'(in_usedw);
    out_w    = 32'(out_usedw);
    wr_top_w = 32'(wr_top);
    rd_top_w = 32'(rd_top);

    out_ok      = OUT_DEPTH > (out_w + BURST);
    wr_ok_arb   = (in_w >= BURST) && (free_w >= BURST);
    wr_ok_drain = (in_w > 0) && (free_w > 0);
    rd_ok_arb   = (fill_w >= BURST) && out_ok;
    rd_ok_drain = (fill_w > 0) && out_ok;

    // A partial drain write is also clamped to free space so fill cannot pass D.
    wr_room = (wr_top_w < free_w) ? wr_top_w : free_w;
    wr_n    = min3(BURST, in_w, wr_room);
    rd_n    = min3(BURST, fill_w, rd_top_w);
  end

  // Scheduler FSM with registered start pulses, burst descriptors and status.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= StIdle;
      draining <= 1'b0;
      wr_start <= 1'b0;
      wr_addr  <= '0;
      wr_num   <= '0;
      rd_start <= 1'b0;
      rd_addr  <= '0;
      rd_num   <= '0;
      data_en  <= 1'b0;
      busy     <= 1'b0;
    end else begin
      wr_start <= 1'b0;
      rd_start <= 1'b0;
      data_en  <= run_start && (state != StDrainArb) && (free_w >= HALT_MARGIN);
      unique case (state)
        StIdle: begin
          if (run_start) begin
            state <= StArb;
          end
        end
        StArb: begin
          if (!run_start) begin
            state    <= StDrainArb;
            draining <= 1'b1;
            busy     <= 1'b1;
          end else if (wr_ok_arb) begin
            state    <= StWrBusy;
            wr_start <= 1'b1;
            wr_addr  <= wr_ptr;
            wr_num   <= FW'(wr_n);
            busy     <= 1'b1;
          end else if (rd_ok_arb) begin
            state    <= StRdBusy;
            rd_start <= 1'b1;
            rd_addr  <= rd_ptr;
            rd_num   <= FW'(rd_n);
            busy     <= 1'b1;
          end
        end
        StWrBusy: begin
          if (wr_run_end) begin
            state <= draining ? StDrainArb : StArb;
            busy  <= draining;
          end
        end
        StRdBusy: begin
          if (rd_run_end) begin
            state <= draining ? StDrainArb : StArb;
            busy  <= draining;
          end
        end
        StDrainArb: begin
          if (run_start) begin
            state    <= StArb;
            draining <= 1'b0;
            busy     <= 1'b0;
          end else if ((in_w == 0) && (fill_w == 0)) begin
            state    <= StIdle;
            draining <= 1'b0;
            busy     <= 1'b0;
          end else if (wr_ok_drain) begin
            state    <= StWrBusy;
            wr_start <= 1'b1;
            wr_addr  <= wr_ptr;
            wr_num   <= FW'(wr_n);
          end else if (rd_ok_drain) begin
            state    <= StRdBusy;
            rd_start <= 1'b1;
            rd_addr  <= rd_ptr;
            rd_num   <= FW'(rd_n);
          end
        end
        default: begin
          state    <= StIdle;
          draining <= 1'b0;
          busy     <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_sram_ring_scheduler.sv
// Scoreboard bench for sram_ring_scheduler with a small ring (D=64, BURST=16).
module tb_sram_ring_scheduler;
  import sram_pkg::*;

  localparam int unsigned ADDR_W = 6;
  localparam int unsigned BURST  = 16;
  localparam int unsigned IN_UW  = 11;
  localparam int unsigned OUT_UW = 7;

  logic              clk = 1'b0;
  logic              reset;
  logic              run_start;
  logic [IN_UW-1:0]  in_usedw;
  logic [OUT_UW-1:0] out_usedw;
  logic              wr_run_end, rd_run_end;
  logic              wr_start, rd_start;
  logic [ADDR_W-1:0] wr_addr, rd_addr;
  logic [ADDR_W:0]   wr_num, rd_num;
  logic              data_en;
  logic [ADDR_W:0]   fill;
  logic              sram_full, sram_empty, busy;

  sram_ring_scheduler #(
    .ADDR_W     (ADDR_W),
    .BURST      (BURST),
    .IN_UW      (IN_UW),
    .OUT_UW     (OUT_UW),
    .OUT_DEPTH  (64),
    .HALT_MARGIN(16)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .run_start (run_start),
    .in_usedw  (in_usedw),
    .out_usedw (out_usedw),
    .wr_run_end(wr_run_end),
    .rd_run_end(rd_run_end),
    .wr_start  (wr_start),
    .wr_addr   (wr_addr),
    .wr_num    (wr_num),
    .rd_start  (rd_start),
    .rd_addr   (rd_addr),
    .rd_num    (rd_num),
    .data_en   (data_en),
    .fill      (fill),
    .sram_full (sram_full),
    .sram_empty(sram_empty),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit          is_wr;
    int unsigned addr;
    int unsigned num;
  } burst_t;

  burst_t exp_q[$];
  int     n_checks = 0;
  int     n_errors = 0;

  task automatic check(input string tag, input int unsigned got, input int unsigned exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic expect_burst(input bit is_wr, input int unsigned addr, input int unsigned num);
    burst_t e;
    e.is_wr = is_wr;
    e.addr  = addr;
    e.num   = num;
    exp_q.push_back(e);
  endtask

  // Wait for the next start pulse, score it, then act as the SRAM controller.
  task automatic service_burst(input bit do_end);
    burst_t      e;
    int unsigned cyc;
    bit          w;
    cyc = 0;
    while (!wr_start && !rd_start && cyc < 60) begin
      @(negedge clk);
      cyc++;
    end
    if (!wr_start && !rd_start) begin
      check("start_timeout", 32'(wr_start | rd_start), 1);
      return;
    end
    if (exp_q.size() == 0) begin
      check("unexpected_start", 32'(exp_q.size()), 1);
      return;
    end
    e = exp_q.pop_front();
    w = wr_start;
    check("start_dir", 32'(w), 32'(e.is_wr));
    check("start_addr", w ? 32'(wr_addr) : 32'(rd_addr), e.addr);
    check("start_num", w ? 32'(wr_num) : 32'(rd_num), e.num);
    check("busy_at_start", 32'(busy), 1);
    if (!do_end) return;
    repeat (3) @(negedge clk);
    check("start_one_shot", w ? 32'(wr_start) : 32'(rd_start), 0);
    check("hold_addr", w ? 32'(wr_addr) : 32'(rd_addr), e.addr);
    check("hold_num", w ? 32'(wr_num) : 32'(rd_num), e.num);
    if (w) begin
      wr_run_end = 1'b1;
      in_usedw   = in_usedw - IN_UW'(e.num);
    end else begin
      rd_run_end = 1'b1;
    end
    @(negedge clk);
    wr_run_end = 1'b0;
    rd_run_end = 1'b0;
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int spurious;
    reset      = 1'b1;
    run_start  = 1'b0;
    in_usedw   = '0;
    out_usedw  = 7'd64;
    wr_run_end = 1'b0;
    rd_run_end = 1'b0;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    check("rst_fill", 32'(fill), 0);
    check("rst_empty", 32'(sram_empty), 1);
    check("rst_full", 32'(sram_full), 0);
    check("rst_busy", 32'(busy), 0);
    check("rst_wr_start", 32'(wr_start), 0);
    check("rst_rd_start", 32'(rd_start), 0);
    check("rst_data_en", 32'(data_en), 0);
    check("rst_wr_num", 32'(wr_num), 0);

    // Basic write with the USB FIFO full: one 16-word write, no read.
    run_start = 1'b1;
    in_usedw  = 11'd20;
    expect_burst(1'b1, 0, 16);
    service_burst(1'b1);
    check("basic_data_en", 32'(data_en), 1);
    spurious = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (wr_start || rd_start) spurious++;
    end
    check("basic_no_read", 32'(spurious), 0);
    check("basic_fill", 32'(fill), 16);
    check("basic_busy_idle", 32'(busy), 0);

    // Walk wr_ptr to 56 with fill 8: two full writes, a drained 8, three reads.
    in_usedw = 11'd40;
    expect_burst(1'b1, 16, 16);
    expect_burst(1'b1, 32, 16);
    service_burst(1'b1);
    service_burst(1'b1);
    run_start = 1'b0;
    expect_burst(1'b1, 48, 8);
    service_burst(1'b1);
    repeat (2) @(negedge clk);
    check("prep_fill56", 32'(fill), 56);
    run_start = 1'b1;
    out_usedw = 7'd0;
    expect_burst(1'b0, 0, 16);
    expect_burst(1'b0, 16, 16);
    expect_burst(1'b0, 32, 16);
    service_burst(1'b1);
    service_burst(1'b1);
    service_burst(1'b1);
    out_usedw = 7'd64;
    repeat (2) @(negedge clk);
    check("prep_fill8", 32'(fill), 8);

    // Wrap split: 8 words up to the top, then the remainder from address 0.
    in_usedw = 11'd16;
    expect_burst(1'b1, 56, 8);
    service_burst(1'b1);
    run_start = 1'b0;
    expect_burst(1'b1, 0, 8);
    service_burst(1'b1);
    repeat (2) @(negedge clk);
    check("wrap_fill", 32'(fill), 24);
    check("drain_busy", 32'(busy), 1);

    // Bring fill to 48 (wr_ptr 32), then write vs read arbitration.
    run_start = 1'b1;
    in_usedw  = 11'd24;
    expect_burst(1'b1, 8, 16);
    service_burst(1'b1);
    run_start = 1'b0;
    expect_burst(1'b1, 24, 8);
    service_burst(1'b1);
    repeat (2) @(negedge clk);
    check("prio_pre_fill", 32'(fill), 48);
    run_start = 1'b1;
    in_usedw  = 11'd16;
    out_usedw = 7'd0;
    expect_burst(1'b1, 32, 16);
    expect_burst(1'b0, 48, 16);
    service_burst(1'b1);
    check("prio_fill64", 32'(fill), 64);
    check("prio_full", 32'(sram_full), 1);
    @(negedge clk);
    check("prio_throttle", 32'(data_en), 0);
    out_usedw = 7'd64;
    service_burst(1'b1);
    repeat (2) @(negedge clk);
    check("prio_after_read", 32'(fill), 48);

    // Empty the ring, then a 5-word drained write to reach fill 5.
    out_usedw = 7'd0;
    expect_burst(1'b0, 0, 16);
    expect_burst(1'b0, 16, 16);
    expect_burst(1'b0, 32, 16);
    service_burst(1'b1);
    service_burst(1'b1);
    service_burst(1'b1);
    out_usedw = 7'd64;
    repeat (2) @(negedge clk);
    check("empty_flag", 32'(sram_empty), 1);
    in_usedw  = 11'd5;
    run_start = 1'b0;
    expect_burst(1'b1, 48, 5);
    service_burst(1'b1);
    run_start = 1'b1;
    in_usedw  = 11'd3;
    repeat (3) @(negedge clk);
    check("drain_pre_fill", 32'(fill), 5);

    // Drain: stop the run, residual write of 3 then read of 8, back to idle.
    run_start = 1'b0;
    out_usedw = 7'd0;
    expect_burst(1'b1, 53, 3);
    expect_burst(1'b0, 48, 8);
    service_burst(1'b1);
    service_burst(1'b1);
    repeat (4) @(negedge clk);
    check("drain_empty", 32'(sram_empty), 1);
    check("drain_busy_done", 32'(busy), 0);
    check("drain_idle", 32'(dut.state), 32'(StIdle));

    // Reset in the middle of a write burst.
    out_usedw = 7'd64;
    run_start = 1'b1;
    in_usedw  = 11'd16;
    expect_burst(1'b1, 56, 8);
    service_burst(1'b0);
    @(negedge clk);
    reset     = 1'b1;
    run_start = 1'b0;
    in_usedw  = '0;
    @(negedge clk);
    check("mid_rst_fill", 32'(fill), 0);
    check("mid_rst_wr_start", 32'(wr_start), 0);
    check("mid_rst_busy", 32'(busy), 0);
    check("mid_rst_state", 32'(dut.state), 32'(StIdle));
    reset      = 1'b0;
    wr_run_end = 1'b1;
    @(negedge clk);
    wr_run_end = 1'b0;
    repeat (2) @(negedge clk);
    check("stray_end_fill", 32'(fill), 0);
    check("stray_end_state", 32'(dut.state), 32'(StIdle));
    run_start = 1'b1;
    in_usedw  = 11'd16;
    expect_burst(1'b1, 0, 16);
    service_burst(1'b1);
    repeat (2) @(negedge clk);
    check("post_rst_fill", 32'(fill), 16);
    check("scoreboard_drained", 32'(exp_q.size()), 0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/sram_ring_scheduler.md
# sram_ring_scheduler

Parametrised burst scheduler that manages the external SRAM as a circular buffer between the acquisition-side SRAM data FIFO and the USB data FIFO. It decides when to issue write bursts (input FIFO → SRAM) and read bursts (SRAM → USB FIFO), and tracks write/read pointers and fill level with wrap-around. It throttles the data generator when the SRAM nears full, and drains residual data as partial bursts when a run stops. It sits between the SRAM FIFO/USB FIFO occupancy counters and the SRAM controller's start/end handshake. It supersedes the single-shot write-then-read control with continuous streaming.

## Interface
Parameters:
- ADDR_W, 15: SRAM word address width; depth D = 2^ADDR_W.
- BURST, 256: nominal burst length in words; power of two; must divide D.
- IN_UW, 11: width of input FIFO used-words count.
- OUT_UW, 14: width of USB FIFO used-words count.
- OUT_DEPTH, 16384: USB FIFO depth in words.
- HALT_MARGIN, 1024: the free-space level in SRAM words below which data_en drops.

Ports (one clock; reset is asynchronous and active-high):
- clk  in  1  system clock, 50 MHz
- reset  in  1  asynchronous, active-high
- run_start  in  1  acquisition enable; level
- in_usedw  in  IN_UW  SRAM data FIFO occupancy
- out_usedw  in  OUT_UW  USB FIFO write-side occupancy
- wr_run_end  in  1  one-cycle pulse from the SRAM controller: the write burst is done
- rd_run_end  in  1  one-cycle pulse from the SRAM controller: the read burst is done
- wr_start  out  1  one-cycle write-burst start pulse
- wr_addr  out  ADDR_W  write burst start address
- wr_num  out  ADDR_W+1  write burst word count (1..BURST)
- rd_start  out  1  one-cycle read-burst start pulse
- rd_addr  out  ADDR_W  read burst start address
- rd_num  out  ADDR_W+1  read burst word count (1..BURST)
- data_en  out  1  gate for the data generator
- fill  out  ADDR_W+1  words currently stored in SRAM (0..D)
- sram_full  out  1  fill == D
- sram_empty  out  1  fill == 0
- busy  out  1  a burst is in flight, or draining is in progress

## Operation
- The state machine has five states: IDLE, ARB, WR_BUSY, RD_BUSY, DRAIN_ARB.
- IDLE: wait for run_start=1, then go to ARB. Pointers and fill are not cleared on a new run; only reset clears them.
- ARB / DRAIN_ARB arbitrate as follows. Writes have priority over reads.
  - Write eligible in ARB: in_usedw ≥ BURST and D − fill ≥ BURST.
  - Write eligible in DRAIN_ARB: in_usedw > 0 and D − fill > 0.
  - Read eligible in ARB: fill ≥ BURST and OUT_DEPTH − out_usedw > BURST.
  - Read eligible in DRAIN_ARB: fill > 0 and the same out-space condition.
- Burst length is n = min(BURST, available, D − ptr). Here available means in_usedw for a write and fill for a read, and ptr is the relevant pointer. A burst therefore never crosses the top of SRAM. The remainder is issued as the next burst starting at address 0.
- Issue: pulse wr_start or rd_start for one cycle, load wr_addr/wr_num or rd_addr/rd_num, and go to WR_BUSY or RD_BUSY.
- WR_BUSY: on wr_run_end, update wr_ptr ← (wr_ptr + wr_num) mod D and fill += wr_num. Return to ARB, or to DRAIN_ARB if draining.
- RD_BUSY: on rd_run_end, update rd_ptr ← (rd_ptr + rd_num) mod D and fill −= rd_num. Return in the same way.
- Stop handling: if run_start=0 is seen in ARB, go to DRAIN_ARB. In DRAIN_ARB, when in_usedw=0 and fill=0, go to IDLE.
- A run_start toggle during a BUSY state does not abort the burst. It is evaluated at the next arbitration.
- If run_start returns to 1 during DRAIN_ARB, go to ARB.
- data_en = run_start and state ≠ DRAIN_ARB and (D − fill) ≥ HALT_MARGIN. It is registered.
- Arithmetic:
  - Pointer addition is modulo D (natural ADDR_W-bit wrap).
  - fill uses ADDR_W+1 bits and never exceeds D or goes below 0; the eligibility rules guarantee this.
  - All comparisons zero-extend to a common width.
- An end pulse that does not match the current BUSY state is ignored.

## Timing
- Reset values: state=IDLE, wr_ptr=rd_ptr=0, fill=0, all outputs 0, sram_empty=1.
- Arbitration takes one cycle. Starts are registered, so the start pulse appears 1 cycle after ARB evaluates eligibility true.
- wr_addr/wr_num and rd_addr/rd_num are stable from the start pulse until the matching end pulse.
- After an end pulse, fill, ptr and flags update on the next edge. The next start can then occur no earlier than 2 cycles after the end pulse.
- busy is high from the start pulse through the end-pulse cycle, and during DRAIN_ARB.
- Asserting reset mid-burst returns everything to its reset values immediately. The SRAM controller must be reset by the same signal.

## Structure
- A shared package, sram_pkg, holds:
  - the state enum;
  - default ADDR_W, BURST and OUT_DEPTH constants;
  - a min3 function used for burst sizing.
- One sub-module, sram_ring_ptr: a pointer register plus the fill counter, with advance-by-n and modulo logic. It is instantiated once for the write side, once for the read side, and shares fill.

## Test plan
Use ADDR_W=6 (D=64), BURST=16, OUT_DEPTH=64 and HALT_MARGIN=16.
- Basic write: run_start=1, in_usedw=20, out FIFO full → wr_start with wr_addr=0, wr_num=16. After wr_run_end, fill=16 and no read is issued.
- Wrap split: set wr_ptr=56 by preceding traffic, fill=8, in_usedw=16 → wr_num=8 at wr_addr=56, then wr_num=8 at wr_addr=0.
- Priority and throttle: fill=48, in_usedw=16, out_usedw=0 → a write is issued first and fill reaches 64. sram_full=1 and data_en=0; the next burst is a read of 16 words.
- Drain: fill=5, in_usedw=3, then run_start falls → write of 3, then read of 8. The block returns to IDLE with sram_empty=1 and busy=0.
- Reset mid-burst: assert reset during WR_BUSY → the next cycle shows fill=0, pointers=0, wr_start=0 and state IDLE. A stray wr_run_end after reset is ignored.
